// File: rtl/dmem_pipe.sv
// dmem_pipe: byte/half/word load-store data RAM with a configurable response latency.
// Latency: resp_valid rises LATENCY cycles after the request is accepted; one request in flight.
// Backpressure: req_ready is low from accept until resp_ready takes the response.
// Optional build macro DMEM_MISALIGN_ERR_EN: misaligned half/word accesses report resp_err
// instead of being force-aligned.
module dmem_pipe #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [1:0]  req_mask,
    input  logic        req_sext,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    // Byte address bits that select a location; higher bits alias.
    localparam int AW    = DEPTH_LOG2 + 2;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = 4;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nx;
    logic            accept;
    logic            load_resp;

    // Request fields held while the access is in flight.
    logic [AW-1:0]   lat_addr;
    logic            lat_we;
    logic [1:0]      lat_mask;
    logic            lat_sext;

    // Fields of the access currently being decoded: live inputs in IDLE, latched otherwise.
    logic [AW-1:0]   src_addr;
    logic            src_we;
    logic [1:0]      src_mask;
    logic            src_sext;

    logic            misaligned;
    logic            acc_err;
    logic [1:0]      off;
    logic [DEPTH_LOG2-1:0] idx;

    logic            wr_en;
    logic [3:0]      wr_be;
    logic [31:0]     wr_lane;

    logic [31:0]     rd_word;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [31:0]     load_val;
    logic [31:0]     rsp_data_nx;
    logic            rsp_err_nx;

    logic [31:0]     mem [DEPTH];

    // State register and latency counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        accept     = 1'b0;
        load_resp  = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        // Single-cycle latency skips WAIT; the response is captured now.
                        state_nx  = RESP;
                        load_resp = 1'b1;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nx  = RESP;
                    load_resp = 1'b1;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                // No new request is taken on the consume edge; IDLE comes first.
                if (resp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Select live request fields in IDLE so a LATENCY of 1 decodes the incoming access.
    always_comb begin
        src_addr = lat_addr;
        src_we   = lat_we;
        src_mask = lat_mask;
        src_sext = lat_sext;
        if (state == IDLE) begin
            src_addr = req_addr[AW-1:0];
            src_we   = req_we;
            src_mask = req_mask;
            src_sext = req_sext;
        end
    end

    // Address decode: alignment check, lane offset and word index.
    always_comb begin
        misaligned = ((src_mask == SZ_HALF) && src_addr[0]) ||
                     ((src_mask == SZ_WORD) && (src_addr[1:0] != 2'b00));
        idx        = src_addr[AW-1:2];
`ifdef DMEM_MISALIGN_ERR_EN
        acc_err = (src_mask == 2'b11) || misaligned;
        off     = src_addr[1:0];
`else
        acc_err = (src_mask == 2'b11);
        // Force-align: drop the low address bits the access size cannot use.
        case (src_mask)
            SZ_HALF: off = {src_addr[1], 1'b0};
            SZ_WORD: off = 2'b00;
            default: off = src_addr[1:0];
        endcase
`endif
    end

    // Store lane enables and replicated write data; stores commit on the accept edge.
    always_comb begin
        wr_be   = 4'b0000;
        wr_lane = req_wdata;
        case (src_mask)
            SZ_BYTE: begin
                wr_be   = 4'b0001 << off;
                wr_lane = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                wr_be   = off[1] ? 4'b1100 : 4'b0011;
                wr_lane = {2{req_wdata[15:0]}};
            end
            SZ_WORD: begin
                wr_be   = 4'b1111;
                wr_lane = req_wdata;
            end
            default: begin
                wr_be   = 4'b0000;
                wr_lane = req_wdata;
            end
        endcase
        wr_en = accept && src_we && !acc_err;
    end

    // RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[idx][8*b +: 8] <= wr_lane[8*b +: 8];
                end
            end
        end
    end

    // Lane extraction and zero/sign extension for loads.
    always_comb begin
        rd_word = mem[idx];
        case (off)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = off[1] ? rd_word[31:16] : rd_word[15:0];
        case (src_mask)
            SZ_BYTE: load_val = src_sext ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
            SZ_HALF: load_val = src_sext ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
            SZ_WORD: load_val = rd_word;
            default: load_val = 32'h0;
        endcase
        rsp_data_nx = (src_we || acc_err) ? 32'h0 : load_val;
        rsp_err_nx  = acc_err;
    end

    // Request latch and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_mask  <= 2'b00;
            lat_sext  <= 1'b0;
            resp_data <= 32'h0;
            resp_err  <= 1'b0;
        end else begin
            if (accept) begin
                lat_addr <= req_addr[AW-1:0];
                lat_we   <= req_we;
                lat_mask <= req_mask;
                lat_sext <= req_sext;
            end
            if (load_resp) begin
                resp_data <= rsp_data_nx;
                resp_err  <= rsp_err_nx;
            end
        end
    end

endmodule

// File: tb/tb_dmem_pipe.sv
// tb_dmem_pipe: directed vector table plus hand-written backpressure and reset sequences.
// Latency: every transaction is checked for a 2-cycle accept-to-response delay.
// Backpressure: resp_ready is normally held high; one sequence holds it low for 5 cycles.
module tb_dmem_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic        req_we = 1'b0;
    logic [1:0]  req_mask = 2'b00;
    logic        req_sext = 1'b0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_data;
    logic        resp_err;

    int n_vec = 0;
    int n_err = 0;

    dmem_pipe #(.DEPTH_LOG2(8), .LATENCY(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_we     (req_we),
        .req_mask   (req_mask),
        .req_sext   (req_sext),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [1:0]  mask;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] edata;
        logic        eerr;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One full transaction with resp_ready high; returns response fields and observed latency.
    task automatic xact(input logic we, input logic [1:0] mask, input logic sext,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_mask  = mask;
        req_sext  = sext;
        req_addr  = addr;
        req_wdata = wd;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = resp_data;
        er = resp_err;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n;

        // we, mask, sext, addr, wdata, expected data, expected err
        tbl.push_back({1'b1, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0});
        tbl.push_back({1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0});
        tbl.push_back({1'b1, 2'b00, 1'b0, 32'h13,  32'h00000080, 32'h0,        1'b0});
        tbl.push_back({1'b0, 2'b00, 1'b1, 32'h13,  32'h0,        32'hFFFFFF80, 1'b0});
        tbl.push_back({1'b0, 2'b00, 1'b0, 32'h13,  32'h0,        32'h00000080, 1'b0});
        tbl.push_back({1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'h80ADBEEF, 1'b0});
        tbl.push_back({1'b0, 2'b01, 1'b1, 32'h12,  32'h0,        32'hFFFF80AD, 1'b0});
        tbl.push_back({1'b0, 2'b01, 1'b1, 32'h10,  32'h0,        32'hFFFFBEEF, 1'b0});
        tbl.push_back({1'b0, 2'b01, 1'b0, 32'h10,  32'h0,        32'h0000BEEF, 1'b0});
        tbl.push_back({1'b1, 2'b10, 1'b0, 32'h400, 32'h12345678, 32'h0,        1'b0});
        tbl.push_back({1'b0, 2'b10, 1'b0, 32'h000, 32'h0,        32'h12345678, 1'b0});
        tbl.push_back({1'b1, 2'b01, 1'b0, 32'h20,  32'hFFFF1234, 32'h0,        1'b0});
        tbl.push_back({1'b1, 2'b01, 1'b0, 32'h22,  32'h00005678, 32'h0,        1'b0});
        tbl.push_back({1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'h56781234, 1'b0});
`ifdef DMEM_MISALIGN_ERR_EN
        tbl.push_back({1'b0, 2'b01, 1'b0, 32'h21,  32'h0,        32'h0,        1'b1});
`else
        tbl.push_back({1'b0, 2'b01, 1'b0, 32'h21,  32'h0,        32'h00001234, 1'b0});
`endif
        tbl.push_back({1'b0, 2'b11, 1'b0, 32'h20,  32'h0,        32'h0,        1'b1});
        tbl.push_back({1'b1, 2'b11, 1'b0, 32'h20,  32'hFFFFFFFF, 32'h0,        1'b1});
        tbl.push_back({1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'h56781234, 1'b0});
        tbl.push_back({1'b1, 2'b00, 1'b0, 32'h21,  32'h000000AB, 32'h0,        1'b0});
        tbl.push_back({1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'h5678AB34, 1'b0});
`ifdef DMEM_MISALIGN_ERR_EN
        tbl.push_back({1'b1, 2'b10, 1'b0, 32'h22,  32'hCAFEF00D, 32'h0,        1'b1});
        tbl.push_back({1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'h5678AB34, 1'b0});
        tbl.push_back({1'b0, 2'b10, 1'b0, 32'h23,  32'h0,        32'h0,        1'b1});
`else
        tbl.push_back({1'b1, 2'b10, 1'b0, 32'h22,  32'hCAFEF00D, 32'h0,        1'b0});
        tbl.push_back({1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'hCAFEF00D, 1'b0});
        tbl.push_back({1'b0, 2'b10, 1'b0, 32'h23,  32'h0,        32'hCAFEF00D, 1'b0});
`endif

        // Reset state while reset is still asserted.
        repeat (2) @(posedge clk);
        #1;
        chk("reset req_ready",  {31'h0, req_ready},  32'h1);
        chk("reset resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("reset resp_data",  resp_data,           32'h0);
        chk("reset resp_err",   {31'h0, resp_err},   32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven transactions.
        for (int i = 0; i < tbl.size(); i++) begin
            xact(tbl[i].we, tbl[i].mask, tbl[i].sext, tbl[i].addr, tbl[i].wdata, rd, er, lat);
            chk($sformatf("vec%0d data", i), rd, tbl[i].edata);
            chk($sformatf("vec%0d err", i), {31'h0, er}, {31'h0, tbl[i].eerr});
            chk($sformatf("vec%0d latency", i), lat, 32'd2);
        end

        // Response held under backpressure; a second request must be ignored.
        xact(1'b1, 2'b10, 1'b0, 32'h10, 32'h80ADBEEF, rd, er, lat);
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_mask   = 2'b10;
        req_addr   = 32'h10;
        @(posedge clk);
        #1;
        req_we    = 1'b1;
        req_wdata = 32'h0;
        n = 0;
        while (!resp_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp latency", n, 32'd2);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d resp_valid", c), {31'h0, resp_valid}, 32'h1);
            chk($sformatf("bp%0d resp_data", c), resp_data, 32'h80ADBEEF);
            chk($sformatf("bp%0d req_ready", c), {31'h0, req_ready}, 32'h0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        req_valid  = 1'b0;
        @(posedge clk);
        #1;
        chk("bp release resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("bp release req_ready",  {31'h0, req_ready},  32'h1);
        xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
        chk("bp ignored store", rd, 32'h80ADBEEF);

        // Reset while a store waits for its response.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_mask  = 2'b10;
        req_addr  = 32'h40;
        req_wdata = 32'hA1B2C3D4;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("wait req_ready", {31'h0, req_ready}, 32'h0);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("midrst req_ready",  {31'h0, req_ready},  32'h1);
        chk("midrst resp_data",  resp_data,           32'h0);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (resp_valid) n++;
        end
        chk("midrst no response", n, 32'd0);
        xact(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lat);
        chk("midrst store kept", rd, 32'hA1B2C3D4);
        chk("midrst store err", {31'h0, er}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_pipe.md
Name: dmem_pipe

Overview:
- Parametrised successor of the single-cycle data memory: byte/half/word load-store memory with configurable depth and configurable response latency.
- Requests use a valid/ready handshake; responses use a valid/ready handshake. One request is outstanding at a time.
- Sits between the core's MEM stage (or a future cache/bus adapter) and on-chip data RAM. Lets the pipeline be tested against non-zero memory latency.

Parameters:
- DEPTH_LOG2, 8, log2 of the number of 32-bit words (default 256 words). Legal range 4..16.
- LATENCY, 2, cycles from request acceptance to the first cycle resp_valid is high. Legal range 1..8.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_addr  in  32  byte address
- req_we  in  1  1 = store, 0 = load
- req_mask  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = reserved
- req_sext  in  1  sign-extend load data (byte/half only)
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes the response
- resp_data  out  32  load data, right-aligned and extended; 0 for stores and errors
- resp_err  out  1  access was rejected

Behaviour:
- Interface: one clock (clk); asynchronous, active-high reset (reset).
- Reset values:
  - State = IDLE, req_ready = 1, resp_valid = 0, resp_data = 0, resp_err = 0, latency counter = 0.
  - RAM contents are not reset.
- FSM states:
  - IDLE: req_ready = 1. When req_valid is high, the request is accepted at that edge: latch addr/we/mask/sext/wdata. Go to WAIT with counter = LATENCY-1; if LATENCY == 1, go directly to RESP.
  - WAIT: req_ready = 0. Decrement the counter each cycle. When the counter reaches 0, go to RESP, loading resp_data and resp_err at that edge.
  - RESP: resp_valid = 1 and req_ready = 0. resp_data and resp_err stay stable until resp_ready is high at an edge, then go to IDLE.
  - A new request cannot be accepted in the same cycle that a response is consumed.
- Latency: for a request accepted at edge N, resp_valid rises after edge N+LATENCY, provided resp_ready has been held high.
- Word index = latched addr[DEPTH_LOG2+1:2]. Higher address bits are ignored, so addresses wrap and alias modulo 4*2^DEPTH_LOG2 bytes.
- Stores:
  - The RAM is written at the accept edge.
  - Byte: lane addr[1:0] gets wdata[7:0]. Half: lane addr[1] gets wdata[15:0]. Word: the full word is written.
  - Lanes not selected are untouched.
  - resp_data = 0 and resp_err = 0.
- Loads:
  - The selected lane is read from the RAM at the edge entering RESP.
  - Byte/half are zero-extended, or sign-extended when the latched sext = 1. Word ignores sext.
- Reserved mask 11: no RAM write, resp_data = 0, resp_err = 1. Latency is still LATENCY.
- Misaligned access (half with addr[0] = 1, or word with addr[1:0] != 0): see Optional Feature.
- Reset asserted mid-operation: return to reset values immediately and drop any pending response. A store already committed at its accept edge remains in the RAM.
- Load after store to the same address: the load returns the stored data, because the store is committed before the load can be accepted.

Optional Feature:
- Macro: DMEM_MISALIGN_ERR_EN.
- Defined: a misaligned access sets resp_err = 1 and resp_data = 0. A misaligned store does not write the RAM.
- Undefined: misaligned addresses are force-aligned by clearing addr[0] for half and addr[1:0] for word. The access then proceeds normally with resp_err = 0.

Test Plan:
- Reset, then store word 0xDEADBEEF at 0x10, then load word at 0x10 (LATENCY = 2, resp_ready = 1). Expect resp_valid exactly 2 cycles after each accept and resp_data = 0xDEADBEEF.
- Store byte 0x80 at 0x13, then load byte at 0x13 with sext = 1 and with sext = 0. Expect 0xFFFFFF80, then 0x00000080; load word 0x10 = 0x80ADBEEF.
- Hold resp_ready low for 5 cycles during a load. Expect resp_valid/resp_data stable, req_ready = 0 and a second req_valid ignored; release resp_ready and expect IDLE the next cycle.
- Store word 0x12345678 at 0x400 with DEPTH_LOG2 = 8, then load word at 0x000. Expect 0x12345678 (wrap-around).
- Load half at 0x21: with DMEM_MISALIGN_ERR_EN expect resp_err = 1, resp_data = 0; without it expect the half at 0x20 and resp_err = 0. Mask 11 gives resp_err = 1 in both builds.
- Assert reset while in WAIT. Expect resp_valid = 0 and req_ready = 1 immediately with no response; a store accepted before the reset reads back intact.
